// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
//   Shared definitions for the reset sequencer: FSM state encoding (which is
//   also the externally visible o_state code), channel-count limit and a
//   lowest-set-bit helper used to pick the next channel to release.
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    localparam logic [1:0] STATE_CODE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_CODE_HOLD    = 2'd1;
    localparam logic [1:0] STATE_CODE_RELEASE = 2'd2;
    localparam logic [1:0] STATE_CODE_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_CODE_IDLE,
        ST_HOLD    = STATE_CODE_HOLD,
        ST_RELEASE = STATE_CODE_RELEASE,
        ST_DONE    = STATE_CODE_DONE
    } seq_state_e;

    localparam int unsigned MAX_CH = 8;

    // Isolates the least significant set bit of mask (zero if mask is zero).
    function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] mask);
        return mask & (~mask + {{(MAX_CH-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/lock_sync.sv
// ---------------------------------------------------------------------------
// lock_sync
//   Two-flop synchroniser for the asynchronous PLL lock flag.
//   Ports:
//     clk      - sampling clock
//     arst_n   - asynchronous active-low reset, output forced to 0
//     async_in - asynchronous input
//     sync_out - synchronised output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module lock_sync (
    input  logic clk,
    input  logic arst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//   Holds all channel resets asserted for HOLD_CYC cycles after the PLL locks,
//   then releases the enabled channels one at a time, lowest index first,
//   STEP_CYC cycles apart. Lock loss returns to IDLE (and is counted); a
//   software request restarts the sequence from HOLD.
//   Ports:
//     clk          - clock, rising edge
//     arst_n       - asynchronous active-low reset
//     i_lock       - asynchronous PLL locked flag
//     i_sw_rst     - synchronous re-sequence request (level)
//     i_ch_en      - per-channel enable, captured on RELEASE entry
//     o_rst_n      - per-channel active-low resets (registered)
//     o_done       - high while in DONE
//     o_state      - current state code (IDLE=0 HOLD=1 RELEASE=2 DONE=3)
//     o_relock_cnt - saturating count of lock-loss events
// ---------------------------------------------------------------------------
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned HOLD_CYC = 65535,
    parameter int unsigned STEP_CYC = 1024
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              i_lock,
    input  logic              i_sw_rst,
    input  logic [NUM_CH-1:0] i_ch_en,
    output logic [NUM_CH-1:0] o_rst_n,
    output logic              o_done,
    output logic [1:0]        o_state,
    output logic [7:0]        o_relock_cnt
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int unsigned STEP_W = $clog2(STEP_CYC + 1);
    localparam int unsigned CNT_W  = (HOLD_W > STEP_W) ? HOLD_W : STEP_W;

    // The down-counter is loaded with N-1 so that a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("rst_sequencer: NUM_CH must be in 1..8");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("rst_sequencer: HOLD_CYC must be at least 1");
    end
    if (STEP_CYC < 1) begin : g_bad_step
        $error("rst_sequencer: STEP_CYC must be at least 1");
    end

    logic              lock_s;
    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    // Enabled channels still waiting to be released; loaded from i_ch_en on
    // RELEASE entry, so it is the latched enable minus already released bits.
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] first_ch;
    logic [NUM_CH-1:0] next_ch;

    lock_sync u_lock_sync (
        .clk      (clk),
        .arst_n   (arst_n),
        .async_in (i_lock),
        .sync_out (lock_s)
    );

    assign first_ch = NUM_CH'(lowest_set(MAX_CH'(i_ch_en)));
    assign next_ch  = NUM_CH'(lowest_set(MAX_CH'(pend)));
    assign o_state  = state;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pend         <= '0;
            o_rst_n      <= '0;
            o_done       <= 1'b0;
            o_relock_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    o_rst_n <= '0;
                    o_done  <= 1'b0;
                    pend    <= '0;
                    if (lock_s) begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_LOAD;
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    // Lock loss outranks a simultaneous software request.
                    if (!lock_s) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        pend    <= '0;
                        o_rst_n <= '0;
                        o_done  <= 1'b0;
                        if (o_relock_cnt != '1) begin
                            o_relock_cnt <= o_relock_cnt + 8'd1;
                        end
                    end else if (i_sw_rst && (state != ST_HOLD)) begin
                        state   <= ST_HOLD;
                        cnt     <= HOLD_LOAD;
                        pend    <= '0;
                        o_rst_n <= '0;
                        o_done  <= 1'b0;
                    end else if (state == ST_HOLD) begin
                        if (cnt == '0) begin
                            // First RELEASE cycle already shows the lowest
                            // enabled channel released.
                            state   <= ST_RELEASE;
                            o_rst_n <= first_ch;
                            pend    <= i_ch_en & ~first_ch;
                            cnt     <= STEP_LOAD;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end else if (state == ST_RELEASE) begin
                        if (pend == '0) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else if (cnt == '0) begin
                            o_rst_n <= o_rst_n | next_ch;
                            pend    <= pend & ~next_ch;
                            cnt     <= STEP_LOAD;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    // DONE holds its outputs until lock loss or i_sw_rst.
                end
            endcase
        end
    end

endmodule
